// File: rtl/snn_ctrl_if.sv
// snn_ctrl_if: signal bundle between snn_ctrl and its neighbours (UART RX/TX,
// SNN core input RAM and core control, status LEDs).
//
// Modports:
//   master : the snn_ctrl side (drives tx/ram/core_start/busy/led)
//   slave  : the environment side (drives rx, tx_ready, core_done/result)
//
// Handshake semantics used throughout this bundle: every strobe
// (rx_rdy, tx_start, ram_we, core_start, core_done) is a single-cycle
// pulse and its accompanying data is valid only in that cycle, except
// tx_data which is held from tx_start until the next send. tx_ready is a
// level: the transmitter is idle and will accept a tx_start pulse.
interface snn_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              tx_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              core_start;
  logic              core_done;
  logic [3:0]        core_result;
  logic              busy;
  logic [7:0]        led;

  modport master (
    input  rx_rdy, rx_data, tx_ready, core_done, core_result,
    output tx_start, tx_data, ram_we, ram_addr, ram_wdata, core_start, busy, led
  );

  modport slave (
    output rx_rdy, rx_data, tx_ready, core_done, core_result,
    input  tx_start, tx_data, ram_we, ram_addr, ram_wdata, core_start, busy, led
  );
endinterface

// File: rtl/snn_ctrl.sv
// snn_ctrl: sequencer between the UART and the SNN inference core.
// Collects NUM_BYTES image bytes from the UART RX stream into the core's
// input RAM, pulses core_start, waits for core_done, and sends the result
// back as one ASCII digit ('?' for results above 9).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : snn_ctrl_if.master (rx, tx, ram write, core control,
//                busy, led)
//
// led: [3:0] last result, [4] overrun sticky, [5] timeout sticky,
//      [7:6] FSM state (LOAD=0, START=1, RUN=2, SEND=3) for debug.
//
// Optional feature: define SNN_CTRL_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYC idle clocks between bytes.
module snn_ctrl #(
  parameter int NUM_BYTES   = 98,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 260400
) (
  input  logic       clk,
  input  logic       rst_n,
  snn_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] byte_cnt;
  logic              last_pend;   // last byte written this cycle -> START next
  logic [3:0]        result;
  logic              ovr_flag;
  logic              tmo_flag;

  logic              tx_start_q;
  logic [7:0]        tx_data_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic              core_start_q;
  logic              busy_q;

  logic              rx_accept;
  logic              tx_fire;
  logic [7:0]        tx_char;
  logic              tmo_hit;

  function automatic logic [7:0] to_ascii(input logic [3:0] r);
    return (r > 4'd9) ? 8'h3F : (8'h30 + {4'h0, r});
  endfunction

  assign rx_accept = bus.rx_rdy && (state == LOAD);

`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Runs only while a frame is partially loaded; any received byte restarts it.
  assign tmo_hit = (state == LOAD) && (byte_cnt != '0) && !bus.rx_rdy &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state != LOAD) || (byte_cnt == '0) || bus.rx_rdy || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  // No timeout: a partial frame waits indefinitely. The comparison is
  // constant false; it only keeps the limit parameter referenced.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  // Next state and transmit decision.
  // tx_fire can happen straight from RUN so that tx_start lands one cycle
  // after core_done when the transmitter is already idle. The registered
  // tx_start marks the send as done, which moves SEND back to LOAD and
  // prevents a second pulse.
  always_comb begin
    state_nxt = state;
    tx_fire   = 1'b0;
    tx_char   = to_ascii(result);
    case (state)
      LOAD: begin
        if (last_pend) state_nxt = START;
      end
      START: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.core_done) begin
          state_nxt = SEND;
          tx_char   = to_ascii(bus.core_result);
          tx_fire   = bus.tx_ready;
        end
      end
      SEND: begin
        if (tx_start_q) state_nxt = LOAD;
        else            tx_fire   = bus.tx_ready;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      byte_cnt     <= '0;
      last_pend    <= 1'b0;
      result       <= 4'h0;
      ovr_flag     <= 1'b0;
      tmo_flag     <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 8'h00;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy_q       <= (state_nxt != LOAD);
      core_start_q <= (state == LOAD) && last_pend;
      tx_start_q   <= tx_fire;
      if (tx_fire) tx_data_q <= tx_char;

      // One-deep write pipeline: a byte accepted this cycle is written next.
      ram_we_q  <= rx_accept;
      last_pend <= 1'b0;
      if (rx_accept) begin
        ram_wdata_q <= bus.rx_data;
        ram_addr_q  <= byte_cnt;
        if (byte_cnt == LAST_IDX) begin
          byte_cnt  <= '0;
          last_pend <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (tmo_hit) begin
        byte_cnt <= '0;
      end

      if ((state == RUN) && bus.core_done) result <= bus.core_result;

      if (bus.rx_rdy && (state != LOAD))         ovr_flag <= 1'b1;
      else if (rx_accept && (byte_cnt == '0))    ovr_flag <= 1'b0;

      if (tmo_hit) tmo_flag <= 1'b1;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.core_start = core_start_q;
  assign bus.busy       = busy_q;
  assign bus.led        = {state, tmo_flag, ovr_flag, result};

endmodule

// File: tb/tb_snn_ctrl.sv
module tb_snn_ctrl;

  localparam int NB = 98;

  logic clk;
  logic rst_n;

  snn_ctrl_if #(.ADDR_W(7)) bus();

  snn_ctrl #(.NUM_BYTES(NB), .ADDR_W(7), .TIMEOUT_CYC(260400)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cs_seen  = 0;
  int cs_exp   = 0;

  logic [14:0] exp_wr_q[$];   // {addr, data}
  logic [7:0]  exp_tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic [14:0] ew;
    logic [7:0]  et;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ram_we) begin
          if (exp_wr_q.size() == 0) begin
            check("ram_we_unexpected", {17'h0, bus.ram_addr, bus.ram_wdata}, 32'hFFFF_FFFF);
          end else begin
            ew = exp_wr_q.pop_front();
            check("ram_write", {17'h0, bus.ram_addr, bus.ram_wdata}, {17'h0, ew});
          end
        end
        if (bus.tx_start) begin
          if (exp_tx_q.size() == 0) begin
            check("tx_start_unexpected", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
          end else begin
            et = exp_tx_q.pop_front();
            check("tx_data", {24'h0, bus.tx_data}, {24'h0, et});
          end
        end
        if (bus.core_start) cs_seen++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left one time unit after a rising edge.
  task automatic send_byte(input logic [7:0] d);
    bus.rx_data = d;
    bus.rx_rdy  = 1'b1;
    @(posedge clk); #1;
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_ram_we"},     {31'h0, bus.ram_we},     32'h0);
    check({tag, "_ram_addr"},   {25'h0, bus.ram_addr},   32'h0);
    check({tag, "_ram_wdata"},  {24'h0, bus.ram_wdata},  32'h0);
    check({tag, "_tx_start"},   {31'h0, bus.tx_start},   32'h0);
    check({tag, "_tx_data"},    {24'h0, bus.tx_data},    32'h0);
    check({tag, "_core_start"}, {31'h0, bus.core_start}, 32'h0);
    check({tag, "_busy"},       {31'h0, bus.busy},       32'h0);
    check({tag, "_led"},        {24'h0, bus.led},        32'h0);
    @(posedge clk); #1;
  endtask

  // Partial frame of n bytes (data = 3*i), all expected to be written.
  task automatic send_partial(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'(3 * i);
      exp_wr_q.push_back({7'(i), d});
      send_byte(d);
      idle(2);
    end
  endtask

  // Full frame: data = base (+ i when incr). Checks overrun clear after the
  // first byte and core_start timing after the last.
  task automatic send_frame(input logic [7:0] base, input logic incr, input int gap);
    logic [7:0] d;
    for (int i = 0; i < NB; i++) begin
      d = incr ? (base + 8'(i)) : base;
      exp_wr_q.push_back({7'(i), d});
      send_byte(d);
      if (i == 0) begin
        @(negedge clk);
        check("ovr_clear_first_byte", {31'h0, bus.led[4]}, 32'h0);
        @(posedge clk); #1;
      end
      if (i != NB - 1) idle(gap);
    end
    cs_exp++;
    @(negedge clk);  // last ram_we cycle
    check("core_start_early", {31'h0, bus.core_start}, 32'h0);
    check("busy_before_start", {31'h0, bus.busy}, 32'h0);
    @(negedge clk);
    check("core_start_pulse", {31'h0, bus.core_start}, 32'h1);
    check("busy_in_start", {31'h0, bus.busy}, 32'h1);
    @(negedge clk);
    check("core_start_width", {31'h0, bus.core_start}, 32'h0);
    check("state_run", {30'h0, bus.led[7:6]}, 32'd2);
    @(posedge clk); #1;
  endtask

  // Core model: answers after dly cycles; optional overrun byte during RUN;
  // optional tx_ready stall of stall cycles starting with core_done.
  task automatic run_core(input logic [3:0] res, input int dly, input int stall,
                          input logic ovr, input logic [7:0] exp_char);
    int bad;
    idle(dly);
    if (ovr) begin
      send_byte(8'h3C);
      @(negedge clk);
      check("ovr_set", {31'h0, bus.led[4]}, 32'h1);
      check("ovr_state_run", {30'h0, bus.led[7:6]}, 32'd2);
      @(posedge clk); #1;
    end
    if (stall > 0) bus.tx_ready = 1'b0;
    exp_tx_q.push_back(exp_char);
    bus.core_done   = 1'b1;
    bus.core_result = res;
    @(posedge clk); #1;
    bus.core_done   = 1'b0;
    bus.core_result = 4'h0;
    if (stall == 0) begin
      @(negedge clk);
      check("tx_start_fast", {31'h0, bus.tx_start}, 32'h1);
      check("busy_at_tx_start", {31'h0, bus.busy}, 32'h1);
    end else begin
      bad = 0;
      repeat (stall) begin
        @(negedge clk);
        if (!bus.busy || bus.tx_start) bad++;
      end
      check("stall_busy_no_tx", bad, 0);
      @(posedge clk); #1;
      bus.tx_ready = 1'b1;
      @(negedge clk);
      check("tx_start_not_early", {31'h0, bus.tx_start}, 32'h0);
      @(negedge clk);
      check("tx_start_after_ready", {31'h0, bus.tx_start}, 32'h1);
      check("busy_at_tx_start", {31'h0, bus.busy}, 32'h1);
    end
    @(negedge clk);
    check("busy_falls", {31'h0, bus.busy}, 32'h0);
    check("tx_start_width", {31'h0, bus.tx_start}, 32'h0);
    check("led_result", {28'h0, bus.led[3:0]}, {28'h0, res});
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : stimulus
    rst_n           = 1'b0;
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.tx_ready    = 1'b1;
    bus.core_done   = 1'b0;
    bus.core_result = 4'h0;

    idle(2);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    idle(2);

    // Partial frame aborted by reset.
    send_partial(40);
    rst_n = 1'b0;
    check_reset_outputs("rst_mid");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Full frame of A5, answer 7.
    send_frame(8'hA5, 1'b0, 3);
    run_core(4'd7, 500, 0, 1'b0, 8'h37);

    // Back-to-back frame, overrun byte during RUN, tx backpressure.
    idle(3);
    send_frame(8'h10, 1'b1, 0);
    run_core(4'd3, 20, 1000, 1'b1, 8'h33);
    check("ovr_sticky_after_send", {31'h0, bus.led[4]}, 32'h1);

    // core_done outside RUN is ignored.
    bus.core_done   = 1'b1;
    bus.core_result = 4'd5;
    @(posedge clk); #1;
    bus.core_done   = 1'b0;
    bus.core_result = 4'd0;
    idle(2);
    @(negedge clk);
    check("stray_done_result", {28'h0, bus.led[3:0]}, 32'd3);
    check("stray_done_busy", {31'h0, bus.busy}, 32'h0);
    @(posedge clk); #1;

    // Next frame clears overrun on its first byte; invalid result -> '?'.
    send_frame(8'h5A, 1'b0, 1);
    run_core(4'd12, 50, 0, 1'b0, 8'h3F);

    idle(5);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("tx_queue_drained", exp_tx_q.size(), 0);
    check("core_start_count", cs_seen, cs_exp);
    check("timeout_led_off", {31'h0, bus.led[5]}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_ctrl.md
# snn_ctrl

Sequencer between the UART receiver/transmitter and the SNN inference core. Collects one packed binary image (784 pixels, 8 per byte) from the UART RX byte stream into the core's input RAM, launches inference, captures the classified digit and returns it as one ASCII byte over UART TX. Sits inside the `SNN` top level, between `uart_rx1`/`uart_tx1` and the core.

## Interface
- `NUM_BYTES`, 98: image bytes per frame.
- `ADDR_W`, 7: input RAM address width; must satisfy 2^ADDR_W >= NUM_BYTES.
- `TIMEOUT_CYC`, 260400: inter-byte timeout in clocks, 10 byte times at 2604 clk/bit. Used only with `SNN_CTRL_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_rdy` in 1: one-cycle pulse from the UART receiver; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `tx_ready` in 1: UART transmitter idle.
- `tx_start` out 1: one-cycle transmit request.
- `tx_data` out 8: byte to transmit; held from `tx_start` until the next send.
- `ram_we` out 1: input RAM write strobe.
- `ram_addr` out ADDR_W: input RAM write address.
- `ram_wdata` out 8: input RAM write data.
- `core_start` out 1: one-cycle inference start pulse.
- `core_done` in 1: one-cycle pulse from the core; `core_result` is valid in that cycle.
- `core_result` in 4: classified digit, 0–9.
- `busy` out 1: high in every state except LOAD.
- `led` out 8: [3:0] last result, [4] overrun sticky, [5] timeout sticky, [7:6] state encoding.

## Operation
- State machine: LOAD → START → RUN → SEND → LOAD.
- LOAD:
  - `byte_cnt` counts 0..NUM_BYTES-1.
  - On `rx_rdy`: register `ram_wdata <= rx_data` and `ram_addr <= byte_cnt`, pulse `ram_we` in the next cycle, then increment `byte_cnt`.
  - On the write of byte NUM_BYTES-1: clear `byte_cnt` and go to START.
- START: pulse `core_start` for one cycle, then go to RUN.
- RUN:
  - Wait for `core_done`.
  - On it, latch `core_result` into `result` and `led[3:0]`, then go to SEND.
- SEND:
  - When `tx_ready` is high, pulse `tx_start` with `tx_data = 8'h30 + result` (ASCII digit), then go to LOAD.
  - While `tx_ready` is low, hold in SEND.
- Overrun: an `rx_rdy` in START, RUN or SEND is discarded and sets `led[4]`. `led[4]` clears on the first byte accepted in LOAD with `byte_cnt == 0`.
- A `core_done` outside RUN is ignored.
- A `core_result` above 9 is transmitted as `8'h3F` (`'?'`).
- Reset asserted mid-frame aborts everything:
  - Partial RAM contents are left as-is.
  - The next frame starts at address 0.

## Timing
- Reset values:
  - State LOAD, `byte_cnt` 0.
  - `tx_start`, `ram_we`, `core_start`, `busy` all 0.
  - `tx_data`, `ram_addr`, `ram_wdata` all 0.
  - `led` 8'h00.
- RAM write latency: `ram_we` is high exactly 1 cycle after the `rx_rdy` cycle, for 1 cycle.
- `core_start` is high in the cycle after the last `ram_we`.
- `tx_start` is asserted 1 cycle after `core_done` when `tx_ready` is already high; otherwise 1 cycle after `tx_ready` rises.
- `busy` rises in the cycle START is entered and falls in the cycle after `tx_start`.
- All outputs are registered; there are no combinational paths from input to output.
- An `rx_rdy` coincident with the last-byte transition is still accepted, because it occurs in LOAD.
- Back-to-back `rx_rdy` on consecutive cycles must be accepted; the write pipeline is one deep and fully pipelined.

## Configuration
- `SNN_CTRL_TIMEOUT_EN` defined:
  - A counter, reset by each `rx_rdy`, runs in LOAD whenever `byte_cnt != 0`.
  - When it reaches TIMEOUT_CYC: `byte_cnt` returns to 0, `led[5]` sets (sticky until reset), and the partial frame is abandoned.
- Undefined: no timeout logic. A partial frame waits indefinitely, and `led[5]` is tied to 0.

## Test plan
- Reset mid-LOAD:
  - Stimulus: 40 bytes, then `rst_n` low for 3 cycles, then a full 98-byte frame.
  - Required: the new frame writes addresses 0..97; all outputs are 0 during reset.
- Full frame:
  - Stimulus: 98 bytes of 8'hA5 at 2604 clk/bit; the core model answers `core_done` with result 7 after 500 cycles.
  - Required: 98 `ram_we` pulses at addresses 0..97 with data A5; one `core_start`; `tx_data` 8'h37 with one `tx_start`; `led[3:0]` = 7.
- Overrun:
  - Stimulus: a byte 8'h3C arrives during RUN.
  - Required: no `ram_we`; `led[4]` = 1. After the next frame's first byte, `led[4]` = 0.
- TX backpressure:
  - Stimulus: `tx_ready` is low for 1000 cycles after `core_done`.
  - Required: `tx_start` comes exactly 1 cycle after `tx_ready` rises; `busy` stays high throughout.
- Invalid result:
  - Stimulus: `core_result` = 12.
  - Required: `tx_data` = 8'h3F.
- Timeout (with `SNN_CTRL_TIMEOUT_EN`):
  - Stimulus: 10 bytes, then idle for 260400 cycles, then 98 bytes.
  - Required: `led[5]` = 1; the second frame starts at address 0; exactly one `core_start`.
